rtc_bus_ctrl: RTL and testbench

//   Drives the multiplexed address/data parallel bus of the external RTC.

---
 rtl/rtc_bus_ctrl_if.sv | 29 ++
 rtl/rtc_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_ctrl_if.sv
// Bus bundle between the RTC controller and its client: request side
// (start/rw/addr/Data), the multiplexed RTC pins and the status outputs.
`timescale 1ns/1ps
interface rtc_bus_ctrl_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] Data;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  modport master (
    output start, rw, addr, Data, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rd_data, busy, done
  );

  modport slave (
    input  start, rw, addr, Data, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rd_data, busy, done
  );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus master for the external RTC: one address
// phase then one data phase, each with programmable setup/pulse/hold.
`timescale 1ns/1ps
module rtc_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 2
) (
  input  logic          clk,
  input  logic          reset,
  rtc_bus_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SETUP, S_A_PULSE, S_A_HOLD, S_GAP,
    S_D_SETUP, S_D_PULSE, S_D_HOLD, S_DONE
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       r_rw;
  logic [7:0] r_addr, r_data;
  logic [7:0] w_addr_eff;

  logic [7:0] r_ad_out, w_ad_out_next;
  logic       r_ad_oe, w_ad_oe_next;
  logic       r_cs_n, w_cs_n_next;
  logic       r_rd_n, w_rd_n_next;
  logic       r_wr_n, w_wr_n_next;
  logic       r_a_d, w_a_d_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic [7:0] r_rd_data;

  function automatic logic [7:0] f_load(input state_t s);
    case (s)
      S_A_SETUP, S_D_SETUP: f_load = 8'(T_SETUP - 1);
      S_A_PULSE, S_D_PULSE: f_load = 8'(T_PULSE - 1);
      S_A_HOLD,  S_D_HOLD:  f_load = 8'(T_HOLD - 1);
      S_GAP:                f_load = 8'(T_GAP - 1);
      default:              f_load = 8'd0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start)    w_state_next = S_A_SETUP;
      S_A_SETUP: if (r_cnt == 8'd0) w_state_next = S_A_PULSE;
      S_A_PULSE: if (r_cnt == 8'd0) w_state_next = S_A_HOLD;
      S_A_HOLD:  if (r_cnt == 8'd0) w_state_next = S_GAP;
      S_GAP:     if (r_cnt == 8'd0) w_state_next = S_D_SETUP;
      S_D_SETUP: if (r_cnt == 8'd0) w_state_next = S_D_PULSE;
      S_D_PULSE: if (r_cnt == 8'd0) w_state_next = S_D_HOLD;
      S_D_HOLD:  if (r_cnt == 8'd0) w_state_next = S_DONE;
      S_DONE:                       w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase

    if (w_state_next != r_state) begin
      w_cnt_next = f_load(w_state_next);
    end else if (r_cnt != 8'd0) begin
      w_cnt_next = r_cnt - 8'd1;
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // The address is not latched yet on the edge that leaves IDLE
  assign w_addr_eff = (r_state == S_IDLE) ? bus.addr : r_addr;

  // Output logic, decoded from the next state so pins move with the state
  always_comb begin
    w_cs_n_next   = 1'b1;
    w_rd_n_next   = 1'b1;
    w_wr_n_next   = 1'b1;
    w_a_d_next    = 1'b1;
    w_ad_oe_next  = 1'b0;
    w_ad_out_next = 8'd0;
    w_busy_next   = (w_state_next != S_IDLE);
    w_done_next   = (w_state_next == S_DONE);
    case (w_state_next)
      S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
        w_cs_n_next   = 1'b0;
        w_a_d_next    = 1'b0;
        w_ad_oe_next  = 1'b1;
        w_ad_out_next = w_addr_eff;
        w_wr_n_next   = (w_state_next != S_A_PULSE);
      end
      S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
        w_cs_n_next = 1'b0;
        if (r_rw) begin
          w_rd_n_next = (w_state_next != S_D_PULSE);
        end else begin
          w_ad_oe_next  = 1'b1;
          w_ad_out_next = r_data;
          w_wr_n_next   = (w_state_next != S_D_PULSE);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, request latch and read capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rw      <= 1'b0;
      r_addr    <= 8'd0;
      r_data    <= 8'd0;
      r_ad_out  <= 8'd0;
      r_ad_oe   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_a_d     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= 8'd0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_rw   <= bus.rw;
        r_addr <= bus.addr;
        r_data <= bus.Data;
      end
      r_ad_out <= w_ad_out_next;
      r_ad_oe  <= w_ad_oe_next;
      r_cs_n   <= w_cs_n_next;
      r_rd_n   <= w_rd_n_next;
      r_wr_n   <= w_wr_n_next;
      r_a_d    <= w_a_d_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      // Sample on the edge that ends the read strobe
      if (r_state == S_D_PULSE && r_cnt == 8'd0 && r_rw) begin
        r_rd_data <= bus.ad_in;
      end
    end
  end

  assign bus.ad_out  = r_ad_out;
  assign bus.ad_oe   = r_ad_oe;
  assign bus.cs_n    = r_cs_n;
  assign bus.rd_n    = r_rd_n;
  assign bus.wr_n    = r_wr_n;
  assign bus.a_d     = r_a_d;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_data = r_rd_data;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: default-timing instance (a) and a
// minimum-timing instance (b) sharing one clock and reset.
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_ctrl_if ba();
  rtc_bus_ctrl_if bb();

  rtc_bus_ctrl #(.T_SETUP(2), .T_PULSE(4), .T_HOLD(2), .T_GAP(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ba));
  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bb));

  localparam int LAT_A = 18;
  localparam int LAT_B = 7;
  localparam int PW_A  = 4;
  localparam int PW_B  = 1;

  int vectors = 0;
  int miscompares = 0;

  // RTC model: drives the read value only while the read strobe is low
  logic [7:0] rdv [2];
  assign ba.ad_in = ba.rd_n ? 8'hEE : rdv[0];
  assign bb.ad_in = bb.rd_n ? 8'hEE : rdv[1];

  typedef struct {
    int         dut;
    int         lat;
    int         pw;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rd;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] exp_rd [2];

  logic       s_cs_n [2], s_rd_n [2], s_wr_n [2], s_a_d [2];
  logic       s_oe [2], s_busy [2], s_done [2];
  logic [7:0] s_out [2], s_rd [2];
  assign s_cs_n[0] = ba.cs_n;   assign s_cs_n[1] = bb.cs_n;
  assign s_rd_n[0] = ba.rd_n;   assign s_rd_n[1] = bb.rd_n;
  assign s_wr_n[0] = ba.wr_n;   assign s_wr_n[1] = bb.wr_n;
  assign s_a_d[0]  = ba.a_d;    assign s_a_d[1]  = bb.a_d;
  assign s_oe[0]   = ba.ad_oe;  assign s_oe[1]   = bb.ad_oe;
  assign s_busy[0] = ba.busy;   assign s_busy[1] = bb.busy;
  assign s_done[0] = ba.done;   assign s_done[1] = bb.done;
  assign s_out[0]  = ba.ad_out; assign s_out[1]  = bb.ad_out;
  assign s_rd[0]   = ba.rd_data; assign s_rd[1]  = bb.rd_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input int i, input logic st, input logic rw,
                       input logic [7:0] a, input logic [7:0] d);
    if (i == 0) begin
      ba.start = st; ba.rw = rw; ba.addr = a; ba.Data = d;
    end else begin
      bb.start = st; bb.rw = rw; bb.addr = a; bb.Data = d;
    end
  endtask

  // Call at a negedge; start is sampled on the following posedge
  task automatic txn(input int i, input logic rw, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] rval, input bit push);
    exp_t e;
    rdv[i] = rval;
    if (push) begin
      if (rw) exp_rd[i] = rval;
      e.dut = i; e.lat = (i == 0) ? LAT_A : LAT_B; e.pw = (i == 0) ? PW_A : PW_B;
      e.rw = rw; e.addr = a; e.data = d; e.rd = exp_rd[i];
      sbq.push_back(e);
      $display("txn dut%0d %s addr=0x%02h data=0x%02h rd_exp=0x%02h",
               i, rw ? "read " : "write", a, d, e.rd);
    end
    drive(i, 1'b1, rw, a, d);
    @(posedge clk);
    #1 drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wait_done(input int i);
    bit found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_done[i]) begin
        found = 1;
        break;
      end
    end
    chk("done_timeout", 32'(found), 32'd1);
  endtask

  // Monitor: pin invariants every cycle, transaction checks at done
  int         cyc [2], awr [2], dwr [2], drd [2];
  logic [7:0] aaddr [2], dout [2];
  logic       doe_any [2], doe_all [2];
  logic       busy_p [2] = '{1'b0, 1'b0};
  logic       done_p [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("inv_rd_wr_both_low", 32'(!s_rd_n[i] && !s_wr_n[i]), 32'd0);
      chk("inv_strobe_without_cs", 32'((!s_rd_n[i] || !s_wr_n[i]) && s_cs_n[i]), 32'd0);
      chk("inv_out_without_oe", 32'(!s_oe[i] && (s_out[i] != 8'd0)), 32'd0);
      if (done_p[i]) chk("busy_after_done", 32'(s_busy[i]), 32'd0);

      if (s_busy[i] && !busy_p[i]) begin
        cyc[i] = 0; awr[i] = 0; dwr[i] = 0; drd[i] = 0;
        aaddr[i] = 8'h00; dout[i] = 8'h00; doe_any[i] = 1'b0; doe_all[i] = 1'b1;
      end else if (s_busy[i]) begin
        cyc[i]++;
      end
      if (!s_cs_n[i] && !s_a_d[i] && !s_wr_n[i]) begin
        awr[i]++;
        aaddr[i] = s_out[i];
      end
      if (!s_cs_n[i] && s_a_d[i]) begin
        if (!s_wr_n[i]) begin
          dwr[i]++;
          dout[i] = s_out[i];
        end
        if (!s_rd_n[i]) drd[i]++;
        doe_any[i] = doe_any[i] | s_oe[i];
        doe_all[i] = doe_all[i] & s_oe[i];
      end

      if (s_done[i]) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: dut%0d pulsed done, required no done", i);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_dut", 32'(i), 32'(e.dut));
          chk("latency", 32'(cyc[i]), 32'(e.lat));
          chk("addr_wr_width", 32'(awr[i]), 32'(e.pw));
          chk("addr_value", 32'(aaddr[i]), 32'(e.addr));
          chk("data_wr_width", 32'(dwr[i]), e.rw ? 32'd0 : 32'(e.pw));
          chk("data_rd_width", 32'(drd[i]), e.rw ? 32'(e.pw) : 32'd0);
          if (e.rw) begin
            chk("read_oe_low", 32'(doe_any[i]), 32'd0);
          end else begin
            chk("write_oe_high", 32'(doe_all[i]), 32'd1);
            chk("write_data", 32'(dout[i]), 32'(e.data));
          end
          chk("rd_data", 32'(s_rd[i]), 32'(e.rd));
          $display("done dut%0d lat=%0d awr=%0d dwr=%0d drd=%0d rd_data=0x%02h",
                   i, cyc[i], awr[i], dwr[i], drd[i], s_rd[i]);
        end
      end
      busy_p[i] = s_busy[i];
      done_p[i] = s_done[i];
    end
  end

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_cs_n"},    32'(s_cs_n[i]), 32'd1);
    chk({tag, "_rd_n"},    32'(s_rd_n[i]), 32'd1);
    chk({tag, "_wr_n"},    32'(s_wr_n[i]), 32'd1);
    chk({tag, "_a_d"},     32'(s_a_d[i]),  32'd1);
    chk({tag, "_ad_oe"},   32'(s_oe[i]),   32'd0);
    chk({tag, "_ad_out"},  32'(s_out[i]),  32'd0);
    chk({tag, "_busy"},    32'(s_busy[i]), 32'd0);
    chk({tag, "_done"},    32'(s_done[i]), 32'd0);
    chk({tag, "_rd_data"}, 32'(s_rd[i]),   32'd0);
  endtask

  initial begin
    reset = 1'b0;
    rdv[0] = 8'h00; rdv[1] = 8'h00;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");
    reset = 1'b1;
    @(negedge clk);

    // Basic write, read, then a write that must not disturb rd_data
    txn(0, 1'b0, 8'h21, 8'h45, 8'h00, 1); wait_done(0);
    @(negedge clk);
    txn(0, 1'b1, 8'h22, 8'h00, 8'h59, 1); wait_done(0);
    repeat (3) @(negedge clk);
    chk("rd_data_hold", 32'(s_rd[0]), 32'h59);
    txn(0, 1'b0, 8'h30, 8'hA5, 8'h00, 1); wait_done(0);
    @(negedge clk);

    // Starts while busy and during DONE are dropped; next cycle is accepted
    txn(0, 1'b0, 8'h40, 8'h12, 8'h00, 1);
    repeat (4) @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'h77, 8'h88);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done(0);
    drive(0, 1'b1, 1'b1, 8'h78, 8'h89);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("start_in_done_ignored", 32'(s_busy[0]), 32'd0);
    txn(0, 1'b0, 8'h41, 8'h34, 8'h00, 1); wait_done(0);
    @(negedge clk);

    // Reset during the data strobe of a write
    txn(0, 1'b0, 8'h55, 8'h66, 8'h00, 0);
    begin
      bit hit = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (!s_wr_n[0] && s_a_d[0]) begin
          hit = 1;
          break;
        end
      end
      chk("reached_d_pulse", 32'(hit), 32'd1);
    end
    chk("pre_reset_rd_data", 32'(s_rd[0]), 32'h59);
    reset = 1'b0;
    @(negedge clk);
    chk_idle(0, "abort");
    reset = 1'b1;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (25) @(negedge clk);
    chk("abort_stays_idle", 32'(s_busy[0]), 32'd0);
    txn(0, 1'b1, 8'h23, 8'h00, 8'h9A, 1); wait_done(0);
    @(negedge clk);

    // Minimum timing instance
    txn(1, 1'b0, 8'h0F, 8'hF0, 8'h00, 1); wait_done(1);
    @(negedge clk);
    txn(1, 1'b1, 8'h10, 8'h00, 8'hC3, 1); wait_done(1);
    @(negedge clk);
    txn(1, 1'b0, 8'hFF, 8'h01, 8'h00, 1); wait_done(1);
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
